// File: rtl/fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder_arbiter
// Purpose  : Round-robin arbiter sharing one multi-cycle single-precision
//            FloatAdder among NumRequesters clients. One operation is in
//            flight at a time because the adder exposes no ready/busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock, Reset      : clock, synchronous active-high reset
//   ReqValid/ReqReady : per-requester request handshake (ReqReady one-hot)
//   ReqOp1/ReqOp2     : packed operands, requester i uses bits [32i+31:32i]
//   AdderOp1/AdderOp2 : latched operands to the FloatAdder
//   AdderInputValid   : one-cycle start pulse to the FloatAdder
//   AdderResult/Valid : FloatAdder result and its qualifier
//   RespValid         : one-hot response pulse to the granted requester
//   RespResult        : returned sum (0 on timeout), held until next response
//   RespTimeout       : qualifies RespValid, operation was abandoned
//   Grant             : index of the current/last granted requester
//   Busy              : high whenever the arbiter is not idle
//   CompletedCount    : wrapping count of responses, timeouts included
// ============================================================================
module fp_adder_arbiter #(
  parameter int NumRequesters = 4,
  parameter int TimeoutCycles = 16,
  parameter int CountWidth    = 16,
  localparam int GrantWidth   = (NumRequesters > 1) ? $clog2(NumRequesters) : 1,
  localparam int TimerWidth   = $clog2(TimeoutCycles)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NumRequesters-1:0]      ReqValid,
  input  logic [NumRequesters*32-1:0]   ReqOp1,
  input  logic [NumRequesters*32-1:0]   ReqOp2,
  output logic [NumRequesters-1:0]      ReqReady,
  output logic [31:0]                   AdderOp1,
  output logic [31:0]                   AdderOp2,
  output logic                          AdderInputValid,
  input  logic [31:0]                   AdderResult,
  input  logic                          AdderResultValid,
  output logic [NumRequesters-1:0]      RespValid,
  output logic [31:0]                   RespResult,
  output logic                          RespTimeout,
  output logic [GrantWidth-1:0]         Grant,
  output logic                          Busy,
  output logic [CountWidth-1:0]         CompletedCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                  state;
  logic [GrantWidth-1:0]   last_grant;
  logic [TimerWidth-1:0]   timer;

  logic                    any_req;
  logic [GrantWidth-1:0]   pick;
  logic [GrantWidth-1:0]   scan_idx;
  logic [31:0]             sel_op1;
  logic [31:0]             sel_op2;

  // Round-robin pick: scan from the farthest candidate back to the nearest
  // one after last_grant, so the last hit is the highest-priority requester.
  always_comb begin
    any_req  = |ReqValid;
    pick     = '0;
    scan_idx = '0;
    for (int i = NumRequesters; i >= 1; i--) begin
      scan_idx = GrantWidth'((int'(last_grant) + i) % NumRequesters);
      if (ReqValid[scan_idx]) begin
        pick = scan_idx;
      end
    end
  end

  // Operand mux for the winner, built with constant slices only.
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (pick == GrantWidth'(i)) begin
        sel_op1 = ReqOp1[i*32 +: 32];
        sel_op2 = ReqOp2[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= S_IDLE;
      last_grant      <= GrantWidth'(NumRequesters - 1);
      timer           <= '0;
      ReqReady        <= '0;
      AdderOp1        <= '0;
      AdderOp2        <= '0;
      AdderInputValid <= 1'b0;
      RespValid       <= '0;
      RespResult      <= '0;
      RespTimeout     <= 1'b0;
      Grant           <= '0;
      Busy            <= 1'b0;
      CompletedCount  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            AdderOp1        <= sel_op1;
            AdderOp2        <= sel_op2;
            Grant           <= pick;
            ReqReady        <= NumRequesters'(1) << pick;
            AdderInputValid <= 1'b1;
            Busy            <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ReqReady        <= '0;
          AdderInputValid <= 1'b0;
          timer           <= '0;
          state           <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the final count beats the timeout.
          if (AdderResultValid) begin
            RespResult  <= AdderResult;
            RespTimeout <= 1'b0;
            RespValid   <= NumRequesters'(1) << Grant;
            state       <= S_RESPOND;
          end else if (timer == TimerWidth'(TimeoutCycles - 1)) begin
            RespResult  <= '0;
            RespTimeout <= 1'b1;
            RespValid   <= NumRequesters'(1) << Grant;
            state       <= S_RESPOND;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESPOND: begin
          RespValid      <= '0;
          RespTimeout    <= 1'b0;
          last_grant     <= Grant;
          CompletedCount <= CompletedCount + 1'b1;
          Busy           <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_adder_arbiter
// Purpose  : Scoreboard bench for fp_adder_arbiter with a behavioural
//            FloatAdder stand-in that answers after a programmable delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_adder_arbiter;

  localparam int N = 4;

  logic          Clock;
  logic          Reset;
  logic [N-1:0]  ReqValid;
  logic [N*32-1:0] ReqOp1;
  logic [N*32-1:0] ReqOp2;
  logic [N-1:0]  ReqReady;
  logic [31:0]   AdderOp1;
  logic [31:0]   AdderOp2;
  logic          AdderInputValid;
  logic [31:0]   AdderResult;
  logic          AdderResultValid;
  logic [N-1:0]  RespValid;
  logic [31:0]   RespResult;
  logic          RespTimeout;
  logic [1:0]    Grant;
  logic          Busy;
  logic [1:0]    CompletedCount;

  fp_adder_arbiter #(
    .NumRequesters(N),
    .TimeoutCycles(16),
    .CountWidth(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ReqValid(ReqValid),
    .ReqOp1(ReqOp1),
    .ReqOp2(ReqOp2),
    .ReqReady(ReqReady),
    .AdderOp1(AdderOp1),
    .AdderOp2(AdderOp2),
    .AdderInputValid(AdderInputValid),
    .AdderResult(AdderResult),
    .AdderResultValid(AdderResultValid),
    .RespValid(RespValid),
    .RespResult(RespResult),
    .RespTimeout(RespTimeout),
    .Grant(Grant),
    .Busy(Busy),
    .CompletedCount(CompletedCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int          idx;
    logic [31:0] op1;
    logic [31:0] op2;
  } grant_t;

  typedef struct {
    int          idx;
    logic [31:0] result;
    logic        timeout;
    int          latency;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];

  int checks = 0;
  int errors = 0;
  int rcount = 0;
  int ops    = 0;
  int cyc    = 0;
  int gcyc   = 0;

  logic [N-1:0] oneshot;
  int           adder_delay;
  logic [31:0]  adder_value;
  logic         spur_toggle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Behavioural adder: pulses ResultValid adder_delay cycles after the start
  // pulse (0 = never answers); a toggle of spur_toggle injects a stray pulse.
  initial begin : adder_model
    int   cnt;
    logic spur_seen;
    cnt = 0;
    spur_seen = 1'b0;
    AdderResultValid = 1'b0;
    AdderResult = 32'h0;
    forever begin
      @(negedge Clock);
      AdderResultValid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          AdderResultValid = 1'b1;
          AdderResult = adder_value;
        end
      end
      if (AdderInputValid === 1'b1 && adder_delay > 0) cnt = adder_delay;
      if (spur_toggle != spur_seen) begin
        spur_seen = spur_toggle;
        AdderResultValid = 1'b1;
        AdderResult = 32'hDEADBEEF;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  initial begin : monitor
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset !== 1'b1) begin
        if (|ReqReady) begin
          if (gq.size() == 0) begin
            check("unexpected_grant", 32'(ReqReady), 32'h0);
          end else begin
            g = gq.pop_front();
            check("req_ready", 32'(ReqReady), 32'(1) << g.idx);
            check("adder_in_valid", 32'(AdderInputValid), 32'h1);
            check("adder_op1", AdderOp1, g.op1);
            check("adder_op2", AdderOp2, g.op2);
            check("grant", 32'(Grant), 32'(g.idx));
            gcyc = cyc;
          end
        end else if (AdderInputValid === 1'b1) begin
          check("stray_adder_in_valid", 32'(AdderInputValid), 32'h0);
        end
        if (|RespValid) begin
          if (rq.size() == 0) begin
            check("unexpected_resp", 32'(RespValid), 32'h0);
          end else begin
            r = rq.pop_front();
            check("resp_valid", 32'(RespValid), 32'(1) << r.idx);
            check("resp_result", RespResult, r.result);
            check("resp_timeout", 32'(RespTimeout), 32'(r.timeout));
            check("resp_latency", 32'(cyc - gcyc), 32'(r.latency));
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    ReqOp1[i*32 +: 32] = a;
    ReqOp2[i*32 +: 32] = b;
  endtask

  task automatic exp_grant(input int i);
    gq.push_back('{i, ReqOp1[i*32 +: 32], ReqOp2[i*32 +: 32]});
  endtask

  task automatic exp_resp(input int i, input logic [31:0] res, input logic to, input int lat);
    rq.push_back('{i, res, to, lat});
    ops++;
  endtask

  // One cycle of requester behaviour: one-shot requesters withdraw after
  // their acceptance pulse.
  task automatic step();
    @(negedge Clock);
    ReqValid = ReqValid & ~(ReqReady & oneshot);
    if (|RespValid) rcount++;
  endtask

  task automatic wait_resps(input int n, input int budget);
    int start;
    int k;
    start = rcount;
    k = 0;
    while ((rcount - start) < n && k < budget) begin
      step();
      k++;
    end
    check("resp_wait_budget", 32'(rcount - start), 32'(n));
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    ops = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(ReqReady), 32'h0);
    check("rst_resp_valid", 32'(RespValid), 32'h0);
    check("rst_adder_in_valid", 32'(AdderInputValid), 32'h0);
    check("rst_resp_timeout", 32'(RespTimeout), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_adder_op1", AdderOp1, 32'h0);
    check("rst_adder_op2", AdderOp2, 32'h0);
    check("rst_resp_result", RespResult, 32'h0);
    check("rst_count", 32'(CompletedCount), 32'h0);
    check("rst_grant", 32'(Grant), 32'h0);
  endtask

  // One single-requester operation with the adder answering after dly cycles.
  task automatic single_op(input int i, input int dly, input logic [31:0] val);
    adder_delay = dly;
    adder_value = val;
    oneshot = N'(1) << i;
    ReqValid = N'(1) << i;
    exp_grant(i);
    exp_resp(i, val, 1'b0, dly + 1);
    wait_resps(1, 60);
    step();
  endtask

  initial begin : stimulus
    int k;
    Reset = 1'b1;
    ReqValid = '0;
    ReqOp1 = '0;
    ReqOp2 = '0;
    oneshot = '0;
    adder_delay = 4;
    adder_value = 32'h0;
    spur_toggle = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 32'h40000000 | 32'(i), 32'h41000000 | 32'(i));

    repeat (3) @(negedge Clock);
    check_reset_outputs();
    Reset = 1'b0;
    @(negedge Clock);

    // Single request from requester 2: 1.0 + 1.0.
    set_ops(2, 32'h3F800000, 32'h3F800000);
    single_op(2, 4, 32'h40000000);
    check("single_count", 32'(CompletedCount), 32'h1);
    check("single_busy_idle", 32'(Busy), 32'h0);
    set_ops(2, 32'h40000002, 32'h41000002);

    // Fairness from reset: all held -> 0,1,2,3,0.
    pulse_reset();
    adder_delay = 2;
    adder_value = 32'h11111111;
    oneshot = '0;
    ReqValid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_grant(j % N);
      exp_resp(j % N, 32'h11111111, 1'b0, 3);
    end
    wait_resps(5, 100);
    // Requester 3 alone so that LastGrant = 3, then 0 and 2 held -> 0,2,0.
    oneshot = 4'b1000;
    ReqValid = 4'b1000;
    exp_grant(3);
    exp_resp(3, 32'h11111111, 1'b0, 3);
    wait_resps(1, 30);
    oneshot = '0;
    ReqValid = 4'b0101;
    exp_grant(0); exp_resp(0, 32'h11111111, 1'b0, 3);
    exp_grant(2); exp_resp(2, 32'h11111111, 1'b0, 3);
    exp_grant(0); exp_resp(0, 32'h11111111, 1'b0, 3);
    wait_resps(3, 60);
    ReqValid = '0;
    step();
    check("fair_count", 32'(CompletedCount), 32'(ops % 4));

    // Timeout: adder never answers -> 16 WAIT cycles, zero result.
    adder_delay = 0;
    oneshot = 4'b0010;
    ReqValid = 4'b0010;
    exp_grant(1);
    exp_resp(1, 32'h0, 1'b1, 17);
    wait_resps(1, 60);
    step();
    single_op(3, 2, 32'h22222222);
    check("timeout_count", 32'(CompletedCount), 32'(ops % 4));

    // Boundary: result on the 16th WAIT cycle wins over the timeout.
    single_op(0, 16, 32'h40400000);
    check("boundary_count", 32'(CompletedCount), 32'(ops % 4));

    // Reset in WAIT: no response, stale result ignored, LastGrant restored.
    adder_delay = 6;
    adder_value = 32'h33333333;
    oneshot = 4'b0100;
    ReqValid = 4'b0100;
    exp_grant(2);
    k = 0;
    while (ReqReady == '0 && k < 20) begin
      step();
      k++;
    end
    check("midwait_grant_seen", 32'(ReqReady), 32'h4);
    repeat (3) step();
    check("midwait_busy", 32'(Busy), 32'h1);
    pulse_reset();
    check_reset_outputs();
    k = rcount;
    repeat (6) step();
    check("midwait_no_resp", 32'(rcount), 32'(k));
    check("midwait_count", 32'(CompletedCount), 32'h0);
    adder_delay = 3;
    adder_value = 32'h44444444;
    oneshot = 4'b0011;
    ReqValid = 4'b0011;
    exp_grant(0); exp_resp(0, 32'h44444444, 1'b0, 4);
    exp_grant(1); exp_resp(1, 32'h44444444, 1'b0, 4);
    wait_resps(2, 60);
    step();

    // Wrap: five operations since reset on a 2-bit counter -> 1.
    single_op(2, 1, 32'h55555555);
    single_op(3, 3, 32'h66666666);
    single_op(0, 2, 32'h77777777);
    check("wrap_count", 32'(CompletedCount), 32'h1);

    // Spurious ResultValid in IDLE: no response, count unchanged.
    k = rcount;
    spur_toggle = ~spur_toggle;
    repeat (4) step();
    check("spurious_no_resp", 32'(rcount), 32'(k));
    check("spurious_count", 32'(CompletedCount), 32'h1);
    check("spurious_busy", 32'(Busy), 32'h0);

    check("grant_queue_drained", 32'(gq.size()), 32'h0);
    check("resp_queue_drained", 32'(rq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
